// File: rtl/sig_shift_frontend.sv
// Serial front end for the pattern detector: shifts the single-bit sig stream
// into either the programmed pattern or the sliding signal window, tracks fill
// levels, and qualifies the downstream equality comparison with cmp_en.
module sig_shift_frontend #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic             prgm,
  output logic [WIDTH-1:0] pat,
  output logic [WIDTH-1:0] win,
  output logic             pat_valid,
  output logic             win_valid,
  output logic             cmp_en
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROG  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] win_q, win_d;
  logic [CW-1:0]    pcnt_q, pcnt_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic             pat_valid_q, pat_valid_d;
  logic             win_valid_q, win_valid_d;
  logic             cmp_en_q, cmp_en_d;

  // Fill counters stop at WIDTH so long bursts never wrap back to "not full".
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == FULL) ? FULL : c + CW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: prgm always wins; dropping prgm decides arm vs. abandon.
  always_comb begin
    state_d = state_q;
    if (prgm) begin
      state_d = S_PROG;
    end else begin
      case (state_q)
        S_PROG:  state_d = (pcnt_q == FULL) ? S_ARMED : S_IDLE;
        S_ARMED: state_d = S_ARMED;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: shift registers, fill counters and qualifier flags.
  always_comb begin
    pat_d       = pat_q;
    win_d       = win_q;
    pcnt_d      = pcnt_q;
    wcnt_d      = wcnt_q;
    pat_valid_d = pat_valid_q;
    win_valid_d = win_valid_q;
    if (prgm) begin
      pat_d = {pat_q[WIDTH-2:0], sig};
      if (state_q == S_PROG) begin
        pcnt_d = sat_inc(pcnt_q);
      end else begin
        // A new programming burst invalidates both the old pattern and window.
        pcnt_d      = CW'(1);
        pat_valid_d = 1'b0;
        win_d       = '0;
        wcnt_d      = '0;
        win_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_PROG: begin
          // The bit on the falling-prgm edge is discarded.
          if (pcnt_q == FULL) begin
            pat_valid_d = 1'b1;
            wcnt_d      = '0;
            win_d       = '0;
          end
        end
        S_ARMED: begin
          win_d  = {win_q[WIDTH-2:0], sig};
          wcnt_d = sat_inc(wcnt_q);
          if (sat_inc(wcnt_q) == FULL) win_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output qualifier: comparison is meaningful only while armed with a full window.
  always_comb begin
    cmp_en_d = (state_d == S_ARMED) && win_valid_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q       <= '0;
      win_q       <= '0;
      pcnt_q      <= '0;
      wcnt_q      <= '0;
      pat_valid_q <= 1'b0;
      win_valid_q <= 1'b0;
      cmp_en_q    <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      win_q       <= win_d;
      pcnt_q      <= pcnt_d;
      wcnt_q      <= wcnt_d;
      pat_valid_q <= pat_valid_d;
      win_valid_q <= win_valid_d;
      cmp_en_q    <= cmp_en_d;
    end
  end

  assign pat       = pat_q;
  assign win       = win_q;
  assign pat_valid = pat_valid_q;
  assign win_valid = win_valid_q;
  assign cmp_en    = cmp_en_q;

endmodule

// File: doc/sig_shift_frontend.md
# sig_shift_frontend

Serial front end for the 4-bit pattern detector: it converts the single-bit `sig` stream into two parallel words, the programmed pattern and the sliding signal window, for the equality comparator. `prgm` selects whether incoming bits load the pattern or feed the window. The block tracks how many bits each register holds and only qualifies the comparison once both are fully populated. The comparator sits directly downstream and consumes `pat`, `win` and `cmp_en`.

## Interface
- `WIDTH`, default 4: pattern/window length in bits (≥2).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sig`  in  1  serial data bit, sampled every rising edge.
- `prgm`  in  1  1 = shift `sig` into pattern register; 0 = shift into signal window (when armed).
- `pat`  out  WIDTH  programmed pattern; newest bit in `pat[0]`.
- `win`  out  WIDTH  signal window; newest bit in `win[0]`.
- `pat_valid`  out  1  pattern holds ≥ WIDTH bits from the most recent programming burst.
- `win_valid`  out  1  window holds ≥ WIDTH bits since arming.
- `cmp_en`  out  1  `pat_valid & win_valid` while ARMED; comparator result is meaningful only when high.

## Operation
- States: IDLE (no valid pattern), PROG (loading pattern), ARMED (pattern valid, streaming).
- Counters `pcnt`, `wcnt`: 0..WIDTH, saturating at WIDTH; width $clog2(WIDTH+1).
- `prgm`=1 sampled in any state: next state PROG; `pat <= {pat[WIDTH-2:0], sig}`.
  - From IDLE/ARMED: `pcnt <= 1`, `pat_valid <= 0`, `win <= 0`, `wcnt <= 0`, `win_valid <= 0`.
  - In PROG: `pcnt <= sat(pcnt+1)`.
  - More than WIDTH bits: shifting continues; pattern = last WIDTH bits.
- `prgm`=0 sampled in PROG: no shift on this edge (bit discarded).
  - `pcnt == WIDTH`: next ARMED, `pat_valid <= 1`, `wcnt <= 0`, `win <= 0`.
  - `pcnt < WIDTH`: next IDLE, `pat_valid` stays 0, `pat` keeps partial bits (invalid).
- `prgm`=0 in ARMED: `win <= {win[WIDTH-2:0], sig}`, `wcnt <= sat(wcnt+1)`; `win_valid <= 1` on the edge where `wcnt` becomes WIDTH; `win_valid` then stays high (sliding window).
- `prgm`=0 in IDLE: no shifting; `win` held at 0; `sig` ignored.
- `cmp_en` registered: high exactly when state = ARMED and `win_valid` = 1.

## Timing
- All outputs registered; nothing combinational from inputs to outputs.
- Reset (`rst_n`=0 at an edge): state IDLE, `pat`=0, `win`=0, `pcnt`=`wcnt`=0, `pat_valid`=`win_valid`=`cmp_en`=0. Takes priority over `prgm`/`sig`, including mid-PROG or mid-stream.
- Bit sampled at edge N is visible in `pat[0]`/`win[0]` after edge N.
- `pat_valid` rises after the first edge at which `prgm`=0 follows ≥WIDTH programming bits (1 cycle after `prgm` falls).
- `win_valid` and `cmp_en` rise after the WIDTH-th streamed bit's edge; stay high until reprogram or reset.
- `prgm` rising in ARMED: `pat_valid`, `win_valid`, `cmp_en` low after that same edge.
- `prgm` held high through reset release: first edge with `rst_n`=1 enters PROG with `pcnt`=1.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with random `sig`/`prgm` -> all outputs 0, state IDLE.
- Program 1,0,1,1 (`prgm`=1 for 4 cycles), then `prgm`=0 -> `pat`=4'b1011, `pat_valid`=1 one cycle after `prgm` falls; `win`=0.
- After arming, stream 1,1,0,1 -> `win_valid`/`cmp_en` rise after 4th bit with `win`=4'b1101; next bit 0 -> `win`=4'b1010, `cmp_en` stays 1.
- Short program 1,0,1 then `prgm`=0 -> IDLE, `pat_valid`=0; 5 more `sig` bits -> `win` stays 0, `cmp_en`=0.
- Reprogram in ARMED with 6 bits 0,0,1,1,0,0 -> flags drop after first `prgm` edge; final `pat`=4'b1100, `pat_valid`=1, `win`=0.
- Assert `rst_n`=0 after 2 of 4 programming bits -> all cleared next edge; after release with `prgm`=0, state IDLE, `pat_valid`=0.
